// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = A - B - BIN, BOUT set when the bit borrows.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic BIN,
    output logic D,
    output logic BOUT
);

    assign D    = A ^ B ^ BIN;
    assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B mod 2^WIDTH, BOUT = (A < B).
// One bit per clock, LSB first; result is published only on the final bit edge
// so D/BOUT never expose a partial difference.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);

    // Counter can hold WIDTH so the final increment never wraps.
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               bw;
    logic [CNT_W-1:0]   cnt;
    logic               fs_d;
    logic               fs_bout;
    logic               last_bit;

    full_subtractor u_fs (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .BIN  (bw),
        .D    (fs_d),
        .BOUT (fs_bout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = START ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = last_bit ? S_FIN : S_RUN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs (BUSY/DONE follow the next state).
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            BOUT   <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            BUSY <= (state_nxt == S_RUN);
            DONE <= (state_nxt == S_FIN);
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a_sr <= A;
                        b_sr <= B;
                        bw   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= {fs_d, res_sr[WIDTH-1:1]};
                    bw     <= fs_bout;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        D    <= {fs_d, res_sr[WIDTH-1:1]};
                        BOUT <= fs_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random-pair bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       BUSY;
    logic       DONE;
    logic [7:0] D;
    logic       BOUT;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation at the current negedge, scramble A/B after accept,
    // then check BUSY length, result, hold of D during RUN, and DONE width.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input string tag);
        logic [7:0] prev_d;
        logic       prev_b;
        logic       moved;
        int         nb;
        prev_d = D;
        prev_b = BOUT;
        moved  = 1'b0;
        START = 1'b1; A = a; B = b;
        @(negedge CLK);
        START = 1'b0; A = 8'($urandom); B = 8'($urandom);
        nb = 0;
        while (BUSY && nb < 40) begin
            if (D !== prev_d || BOUT !== prev_b || DONE !== 1'b0) moved = 1'b1;
            nb++;
            @(negedge CLK);
        end
        chk({tag, "_busy_len"}, nb, 8);
        chk({tag, "_hold"}, moved, 0);
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_d"}, D, ed);
        chk({tag, "_bout"}, BOUT, eb);
        @(negedge CLK);
        chk({tag, "_done_off"}, DONE, 0);
        chk({tag, "_idle"}, BUSY, 0);
    endtask

    initial begin
        int dones;
        int nb;
        logic [7:0] ra;
        logic [7:0] rb;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_d", D, 0);
        chk("rst_bout", BOUT, 0);
        START = 1'b1;            // must be overridden by reset
        @(negedge CLK);
        chk("rst_over_start", BUSY, 0);
        START = 1'b0;
        RST = 1'b0;
        @(negedge CLK);

        // Directed vectors
        do_op(8'h5A, 8'h23, 8'h37, 1'b0, "v5a_23");
        do_op(8'h00, 8'h01, 8'hFF, 1'b1, "v00_01");
        do_op(8'h80, 8'h80, 8'h00, 1'b0, "v80_80");
        do_op(8'hFF, 8'h00, 8'hFF, 1'b0, "vff_00");
        do_op(8'h00, 8'hFF, 8'h01, 1'b1, "v00_ff");

        // START held high; operands change during RUN; FIN ignores START
        START = 1'b1; A = 8'h10; B = 8'h01;
        @(negedge CLK);
        A = 8'hFF; B = 8'hFF;
        dones = 0; nb = 0;
        while (!DONE && nb < 40) begin nb++; @(negedge CLK); end
        chk("hold_start_done", DONE, 1);
        chk("hold_start_d", D, 8'h0F);
        chk("hold_start_bout", BOUT, 0);
        @(negedge CLK);
        chk("hold_start_fin_ignored", BUSY, 0);
        chk("hold_start_single_done", DONE, 0);
        @(negedge CLK);
        chk("hold_start_reaccept", BUSY, 1);
        START = 1'b0;
        nb = 0;
        while (!DONE && nb < 40) begin nb++; @(negedge CLK); end
        chk("hold_start2_d", D, 8'h00);
        @(negedge CLK);

        // Prior result nonzero so reset clearing of D/BOUT is visible
        do_op(8'h00, 8'h01, 8'hFF, 1'b1, "pre_rst");
        START = 1'b1; A = 8'h5A; B = 8'h23;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort_busy_before", BUSY, 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_busy", BUSY, 0);
        chk("abort_d", D, 0);
        chk("abort_bout", BOUT, 0);
        dones = 0;
        repeat (12) begin
            if (DONE) dones++;
            @(negedge CLK);
        end
        chk("abort_no_done", dones, 0);
        RST = 1'b0; START = 1'b1; A = 8'h03; B = 8'h05;
        @(negedge CLK);
        chk("post_rst_accept", BUSY, 1);
        START = 1'b0;
        nb = 0;
        while (!DONE && nb < 40) begin nb++; @(negedge CLK); end
        chk("post_rst_d", D, 8'hFE);
        chk("post_rst_bout", BOUT, 1);
        @(negedge CLK);

        // Back-to-back random pairs against {A<B, A-B mod 256}
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 50 == 0) rb = ra;
            do_op(ra, rb, ra - rb, (ra < rb), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width (legal range 2..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port START  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  minuend, captured on the START-accept edge.
REQ-006 SHALL have port B  input  WIDTH  subtrahend, captured on the START-accept edge.
REQ-007 SHALL have port BUSY  output  1  high while bits are being processed (RUN state).
REQ-008 SHALL have port DONE  output  1  single-cycle pulse marking valid D/BOUT.
REQ-009 SHALL have port D  output  WIDTH  difference A-B modulo 2^WIDTH.
REQ-010 SHALL have port BOUT  output  1  final borrow; 1 when A < B (unsigned).

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, FIN.
REQ-012 IDLE: START=1 at an edge SHALL latch A and B into internal shift registers, clear borrow, clear bit counter and move to RUN.
REQ-013 RUN: each edge SHALL process one bit LSB-first: diff = a^b^bw; bw_next = (~a&b) | (~(a^b)&bw); shift operands right; shift diff into result register MSB end.
REQ-014 RUN SHALL last exactly WIDTH edges; the edge processing bit WIDTH-1 SHALL load D and BOUT from the result register and final borrow, and move to FIN.
REQ-015 FIN SHALL assert DONE for exactly one cycle, then return to IDLE on the next edge unconditionally.
REQ-016 Latency: START sampled at edge k gives DONE=1 in the cycle following edge k+WIDTH; the earliest next accept is edge k+WIDTH+2.
REQ-017 BUSY SHALL be 1 exactly in RUN; DONE exactly in FIN; both SHALL be registered (no combinational path from inputs).
REQ-018 START during RUN or FIN SHALL be ignored, with no effect on the operation in progress.
REQ-019 Changes on A/B after the accept edge SHALL NOT affect the result.
REQ-020 D and BOUT SHALL hold the last completed result until the next completion edge; they SHALL NOT show partial results during RUN.
REQ-021 A==B SHALL give D=0, BOUT=0; A<B SHALL give the two's-complement wrap D=2^WIDTH+A-B, BOUT=1.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-023 RST=1 at an edge SHALL force IDLE, BUSY=0, DONE=0, D=0, BOUT=0, and clear counter, borrow and shift registers; RST overrides START.
REQ-024 RST asserted mid-RUN SHALL abort the operation with no DONE pulse; START is accepted on the first edge with RST=0.

Structure
REQ-025 State encodings (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and default WIDTH SHALL live in the shared package serial_sub_pkg.
REQ-026 The per-bit diff/borrow logic SHALL be a combinational sub-module full_subtractor (inputs A, B, BIN; outputs D, BOUT), instantiated once.
REQ-027 Unused encoding 2'd3 SHALL return to IDLE on the next edge.

Verification
REQ-028 WIDTH=8, A=0x5A, B=0x23, START pulse -> BUSY for 8 cycles, DONE one cycle later, D=0x37, BOUT=0.
REQ-029 A=0x00, B=0x01 -> D=0xFF, BOUT=1; A=0x80, B=0x80 -> D=0x00, BOUT=0.
REQ-030 START held high continuously with A=0x10, B=0x01, and A/B changed to 0xFF/0xFF during RUN -> single DONE with D=0x0F; the next accept occurs only after FIN.
REQ-031 RST pulsed at RUN cycle 4 -> BUSY=0, DONE never pulses, D=0, BOUT=0; a fresh START with A=0x03, B=0x05 -> D=0xFE, BOUT=1.
REQ-032 Back-to-back operations (START reasserted at the first IDLE edge) over 1000 random pairs -> every DONE matches the reference model {BOUT,D} = {A<B, A-B mod 256}, and D is stable between DONE pulses.
